// File: rtl/receptor_destinos_if.sv
// Bus bundle for receptor_destinos: destination FIFO read side plus the
// valid/ready sink port (a word moves on a rising edge where valid && ready).
interface receptor_destinos_if;
    logic       D0_empty;
    logic       D1_empty;
    logic [5:0] data_out0;
    logic [5:0] data_out1;
    logic       pop_D0;
    logic       pop_D1;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
    logic       out_dest;

    modport master (
        input  D0_empty, D1_empty, data_out0, data_out1, out_ready,
        output pop_D0, pop_D1, out_valid, out_data, out_dest
    );

    modport slave (
        output D0_empty, D1_empty, data_out0, data_out1, out_ready,
        input  pop_D0, pop_D1, out_valid, out_data, out_dest
    );
endinterface

// File: rtl/receptor_destinos.sv
// Round-robin reader of two destination FIFOs into a 2-entry output buffer.
// Define RECEPTOR_COUNTERS_EN to build the per-destination delivery counters.
module receptor_destinos (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    receptor_destinos_if.master    bus,
    output logic [7:0]             count_D0,
    output logic [7:0]             count_D1,
    output logic                   idle_rx,
    output logic [1:0]             dbg_state
);
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [1:0] occ, occ_after, occ_nx;
    logic       inflight, inflight_dest, last_grant;
    logic [6:0] slot0, slot1, slot0_nx, slot1_nx, cap_word;
    logic [2:0] load;
    logic       fire, can_pop, sel_d1, pop0, pop1, any_work;

    always_comb begin
        fire     = (occ != 2'd0) && bus.out_ready;
        // Words already committed to the buffer after this edge's sink transfer.
        load     = {1'b0, occ} + {2'b0, inflight} - {2'b0, fire};
        can_pop  = (state == ST_IDLE || state == ST_ACTIVE) && !init && (load < 3'd2);
        if (!bus.D0_empty && !bus.D1_empty)
            sel_d1 = ~last_grant;
        else
            sel_d1 = bus.D0_empty;
        pop0     = can_pop && !sel_d1 && !bus.D0_empty;
        pop1     = can_pop &&  sel_d1 && !bus.D1_empty;
        any_work = !bus.D0_empty || !bus.D1_empty || (occ != 2'd0) || inflight;
    end

    always_comb begin
        cap_word  = {inflight_dest, inflight_dest ? bus.data_out1 : bus.data_out0};
        occ_after = occ - {1'b0, fire};
        slot0_nx  = slot0;
        slot1_nx  = slot1;
        if (fire)
            slot0_nx = slot1;
        if (inflight) begin
            if (occ_after == 2'd0)
                slot0_nx = cap_word;
            else
                slot1_nx = cap_word;
        end
        occ_nx = occ_after + {1'b0, inflight};
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RESET:  state_nx = init ? ST_INIT : ST_IDLE;
            ST_INIT:   if (!init) state_nx = ST_IDLE;
            ST_IDLE:   if (any_work) state_nx = ST_ACTIVE;
            ST_ACTIVE: if (!any_work) state_nx = ST_IDLE;
            default:   state_nx = ST_RESET;
        endcase
        if (init)
            state_nx = ST_INIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_RESET;
            occ           <= 2'd0;
            inflight      <= 1'b0;
            inflight_dest <= 1'b0;
            last_grant    <= 1'b1;
            slot0         <= 7'd0;
            slot1         <= 7'd0;
        end else begin
            state <= state_nx;
            if (init) begin
                // A word still in flight from an earlier pop is dropped here.
                occ        <= 2'd0;
                inflight   <= 1'b0;
                last_grant <= 1'b1;
            end else begin
                occ      <= occ_nx;
                inflight <= pop0 | pop1;
                slot0    <= slot0_nx;
                slot1    <= slot1_nx;
                if (pop0 | pop1) begin
                    inflight_dest <= pop1;
                    last_grant    <= pop1;
                end
            end
        end
    end

`ifdef RECEPTOR_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_D0 <= 8'd0;
            count_D1 <= 8'd0;
        end else if (init) begin
            count_D0 <= 8'd0;
            count_D1 <= 8'd0;
        end else if (fire) begin
            if (!slot0[6] && count_D0 != 8'hFF) count_D0 <= count_D0 + 8'd1;
            if ( slot0[6] && count_D1 != 8'hFF) count_D1 <= count_D1 + 8'd1;
        end
    end
`else
    assign count_D0 = 8'd0;
    assign count_D1 = 8'd0;
`endif

    assign bus.pop_D0    = pop0;
    assign bus.pop_D1    = pop1;
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = slot0[5:0];
    assign bus.out_dest  = slot0[6];
    assign idle_rx       = (state == ST_IDLE);
    assign dbg_state     = state;
endmodule

// File: doc/receptor_destinos.md
RECEPTOR_DESTINOS -- requirements
Module: receptor_destinos

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: init  in  1  synchronous clear of buffer, counters and arbiter; no pops while high.
REQ-004 SHALL have ports: D0_empty, D1_empty  in  1 each  empty flags of destination FIFOs D0/D1.
REQ-005 SHALL have ports: data_out0, data_out1  in  6 each  read data of D0/D1, valid the cycle after the pop.
REQ-006 SHALL have ports: pop_D0, pop_D1  out  1 each  pop requests to D0/D1.
REQ-007 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  6; out_dest  out  1 (0=D0, 1=D1); valid/ready sink handshake.
REQ-008 SHALL have ports: count_D0, count_D1  out  8 each  words delivered per destination.
REQ-009 SHALL have ports: idle_rx  out  1  high in IDLE state.

Function
REQ-010 SHALL hold a 2-entry FIFO output buffer (occ 0..2); the head drives out_data/out_dest; out_valid = (occ != 0).
REQ-011 SHALL pop the head on the rising edge where out_valid && out_ready.
REQ-012 SHALL register inflight = (pop_D0 | pop_D1) and capture data_outX plus its dest into the buffer on the next edge (read latency 1).
REQ-013 SHALL drive pop_D0/pop_D1 combinationally from registered state; at most one high per cycle; pop only in ACTIVE/IDLE, init low, selected FIFO not empty, and occ + inflight - (out_valid && out_ready) < 2.
REQ-014 SHALL arbitrate round-robin: one FIFO non-empty -> that one; both non-empty -> the one not granted last; last_grant updates only on an actual pop.
REQ-015 SHALL, when capture and sink pop coincide, do both in the same edge (occ unchanged); back-to-back throughput 1 word/cycle with out_ready held high.
REQ-016 SHALL never overflow the buffer; with out_ready low, pops stop once occ + inflight = 2 and the buffer contents are held stable.
REQ-017 SHALL increment count_D0/count_D1 on each accepted sink transfer of that dest; saturate at 255.
REQ-018 SHALL implement FSM: RESET -> INIT (init high) / IDLE (init low); INIT -> IDLE when init low; IDLE -> ACTIVE when either FIFO non-empty or occ != 0 or inflight; ACTIVE -> IDLE when both FIFOs empty, occ = 0, inflight = 0; any state -> INIT on init high.
REQ-019 SHALL, in INIT, clear occ, inflight, counters and last_grant (=1, so D0 wins first tie); data from a pop issued before init is discarded.

Reset
REQ-020 SHALL, on reset high, asynchronously force: state RESET, pop_D0 = pop_D1 = 0, out_valid = 0, out_data = 0, out_dest = 0, occ = 0, inflight = 0, counts = 0, idle_rx = 0, last_grant = 1.
REQ-021 SHALL leave RESET on the first edge after reset deasserts; data in flight at reset assertion is lost.

Configuration
REQ-022 SHALL, with macro RECEPTOR_COUNTERS_EN defined, implement count_D0/count_D1 per REQ-017.
REQ-023 SHALL, without RECEPTOR_COUNTERS_EN, tie count_D0/count_D1 to 0 and synthesize no counter registers; all other behaviour identical.

Verification
REQ-024 SHALL cover: D0 holds 3 words 0x01,0x02,0x03, D1 empty, out_ready=1 -> pop_D0 3 consecutive cycles, out_data 0x01,0x02,0x03 on consecutive cycles, out_dest=0, count_D0=3.
REQ-025 SHALL cover: both FIFOs hold 2 words (D0 0x0A,0x0B; D1 0x2A,0x2B) after reset -> order D0,D1,D0,D1; out_data 0x0A,0x2A,0x0B,0x2B.
REQ-026 SHALL cover: out_ready low, D0 has 5 words -> exactly 2 pops, occ=2, out_data held 0x first word; raising out_ready drains all 5 in order with no loss/duplication.
REQ-027 SHALL cover: 260 transfers from D1 -> count_D1 = 255 (saturated); without RECEPTOR_COUNTERS_EN -> count_D1 = 0.
REQ-028 SHALL cover: reset asserted mid-burst between two clock edges -> out_valid and pops drop to 0 immediately; after release with FIFOs empty -> IDLE, idle_rx=1.
REQ-029 SHALL cover: init pulsed 1 cycle while occ=2 -> next cycle occ=0, counters 0, no pop while init high, first pop after init from D0 on tie.
